udp_ack_tx_arbiter: RTL
=======================

// Module: udp_ack_tx_arbiter
// PURPOSE
//  Packet-level round-robin arbiter sharing one UDP TX AXIS path among NUM_REQ ack/response sources.
//  Sources include host ack generators and key-lookup responders.
//  A grant is held from the first beat to the tlast beat, so packets never interleave.
//  A registered output stage carries data/keep/last plus size/src/dst metadata to the UDP TX engine.
// PARAMETERS
//  NUM_REQ   4     number of requesters (>=2)
//  DATA_W    512   tdata width
//  KEEP_W    64    tkeep width (DATA_W/8)
//  META_W    16    width of each of size/src/dst
//  IDX_W     2     $clog2(NUM_REQ)
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               reset, synchronous, active-low
//  s_valid        in   NUM_REQ         per-requester tvalid
//  s_ready        out  NUM_REQ         per-requester tready
//  s_data         in   NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//  s_keep         in   NUM_REQ*KEEP_W  per-requester tkeep
//  s_last         in   NUM_REQ         per-requester tlast
//  s_size         in   NUM_REQ*META_W  packet byte count
//  s_src          in   NUM_REQ*META_W  source port id
//  s_dst          in   NUM_REQ*META_W  destination port id
//  m_valid        out  1               output tvalid (registered)
//  m_ready        in   1               output tready
//  m_data         out  DATA_W          output tdata
//  m_keep         out  KEEP_W          output tkeep
//  m_last         out  1               output tlast
//  m_size/m_src/m_dst out META_W       output metadata
//  m_id           out  IDX_W           index of the requester that owns the current beat
// BEHAVIOUR
//  Reset: state=IDLE; m_valid=0; m_data/m_keep/m_last/m_size/m_src/m_dst/m_id=0; s_ready=0; last_grant=NUM_REQ-1, so requester 0 wins first.
//  out_free = !m_valid || m_ready. This is a combinational path from m_ready to s_ready.
//  IDLE: s_ready=0. If any s_valid, pick the first requester with s_valid set, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
//    The winner is latched into grant; state goes to BUSY next cycle.
//  BUSY: s_ready[grant]=out_free; all other s_ready=0.
//    A beat is accepted when s_valid[grant] && s_ready[grant].
//    Accept: output regs load the granted lane's data/keep/last/size/src/dst; m_id=grant; m_valid=1.
//    Accept with s_last=1: last_grant<=grant; state->IDLE.
//  Output: m_valid && m_ready with no new accept in the same cycle clears m_valid. Accept and drain together keep m_valid=1 with new contents.
//  Latency: request at IDLE cycle t -> s_ready at t+1 (if out_free) -> m_valid at t+2. There is a 1-cycle arbitration bubble per packet.
//    Beats within a packet stream at 1 per cycle under continuous m_ready.
//  Grant is never revoked mid-packet: s_valid[grant] dropping in BUSY only stalls, and other requesters wait.
//  Output regs hold stable while m_valid && !m_ready (AXIS rule). Requester lanes must hold their own data until accepted.
//  Single-beat packets (e.g. 9-byte acks, keep=64'h1FF, last=1) complete BUSY in one accept.
//  Metadata is captured per beat. Sources hold size/src/dst constant across a packet.
//  Reset mid-packet: everything returns to reset values immediately. The partial packet is dropped, and no beat from it appears after reset.
// TESTING
//  1. Only req1 sends 1-beat pkt (data=0xAB..FF, keep=0x1FF, size=9) -> m_valid at t+2, m_id=1, identical data/keep/size, m_last=1.
//  2. All 4 hold 1-beat pkts, m_ready=1 -> grant order 0,1,2,3,0,... with one idle cycle between output beats.
//  3. req0 sends 3-beat pkt while req2 requests -> 3 req0 beats contiguous on m_*, then req2; no interleaving.
//  4. m_ready=0 for 5 cycles mid-packet -> m_* stable, s_ready[grant]=0, no beat lost or duplicated after release.
//  5. rst_n=0 during beat 2 of 4 -> next cycle m_valid=0, state IDLE, req0 priority; no stale beats after reset.
//  6. req3 sends last beat while req0,req3 both request -> next grant is req0 (wrap from last_grant=3).

Source files
------------

// File: rtl/udp_ack_tx_arbiter.sv
// Packet-level round-robin arbiter that merges NUM_REQ AXIS ack/response
// sources onto one UDP TX path. A requester keeps the grant from its first
// beat to its tlast beat, and beats leave through a registered output stage.
module udp_ack_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 512,
    parameter int KEEP_W  = 64,
    parameter int META_W  = 16,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        s_valid,
    output logic [NUM_REQ-1:0]        s_ready,
    input  logic [NUM_REQ*DATA_W-1:0] s_data,
    input  logic [NUM_REQ*KEEP_W-1:0] s_keep,
    input  logic [NUM_REQ-1:0]        s_last,
    input  logic [NUM_REQ*META_W-1:0] s_size,
    input  logic [NUM_REQ*META_W-1:0] s_src,
    input  logic [NUM_REQ*META_W-1:0] s_dst,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [KEEP_W-1:0]         m_keep,
    output logic                      m_last,
    output logic [META_W-1:0]         m_size,
    output logic [META_W-1:0]         m_src,
    output logic [META_W-1:0]         m_dst,
    output logic [IDX_W-1:0]          m_id
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_lastGrant;
    logic [IDX_W-1:0] w_winIdx;
    logic [IDX_W-1:0] w_scan;
    logic             w_winValid;
    logic             w_outFree;
    logic             w_accept;
    logic             w_laneLast;

    logic [DATA_W-1:0] w_laneData;
    logic [KEEP_W-1:0] w_laneKeep;
    logic [META_W-1:0] w_laneSize;
    logic [META_W-1:0] w_laneSrc;
    logic [META_W-1:0] w_laneDst;

    // The output register can take a beat when empty or when it drains this cycle.
    assign w_outFree  = !m_valid || m_ready;
    assign w_accept   = (r_state == BUSY) && s_valid[r_grant] && w_outFree;
    assign w_laneLast = s_last[r_grant];

    assign w_laneData = s_data[r_grant*DATA_W +: DATA_W];
    assign w_laneKeep = s_keep[r_grant*KEEP_W +: KEEP_W];
    assign w_laneSize = s_size[r_grant*META_W +: META_W];
    assign w_laneSrc  = s_src[r_grant*META_W +: META_W];
    assign w_laneDst  = s_dst[r_grant*META_W +: META_W];

    // Round-robin pick: scan downward so the nearest requester after last_grant wins.
    always_comb begin
        w_winValid = 1'b0;
        w_winIdx   = '0;
        w_scan     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_scan = IDX_W'((int'(r_lastGrant) + k) % NUM_REQ);
            if (s_valid[w_scan]) begin
                w_winValid = 1'b1;
                w_winIdx   = w_scan;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and per-lane ready; only the granted lane ever sees ready.
    always_comb begin
        w_nextState = r_state;
        s_ready     = '0;
        case (r_state)
            IDLE: begin
                if (w_winValid) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                s_ready[r_grant] = w_outFree;
                if (w_accept && w_laneLast) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Grant is latched at arbitration; last_grant moves only when a packet completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant     <= '0;
            r_lastGrant <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (r_state == IDLE && w_winValid) begin
                r_grant <= w_winIdx;
            end
            if (w_accept && w_laneLast) begin
                r_lastGrant <= r_grant;
            end
        end
    end

    // Registered output stage: load on accept, otherwise drop valid once drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_size  <= '0;
            m_src   <= '0;
            m_dst   <= '0;
            m_id    <= '0;
        end else if (w_accept) begin
            m_valid <= 1'b1;
            m_data  <= w_laneData;
            m_keep  <= w_laneKeep;
            m_last  <= w_laneLast;
            m_size  <= w_laneSize;
            m_src   <= w_laneSrc;
            m_dst   <= w_laneDst;
            m_id    <= r_grant;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
